// File: rtl/cnt_sched_pkg.sv
// cnt_sched_pkg: shared types for the counter scheduler.
// Holds the FSM state enum, default sizes and the round-robin picker.
package cnt_sched_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_CNT_W = 4;
    localparam int MAX_REQ   = 8;
    localparam int IDX_W     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First requester after ptr (wrapping at n) whose bit is set.
    function automatic rr_pick_t rr_next(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int                 n
    );
        rr_pick_t r;
        int       idx;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= n && !r.valid) begin
                idx = int'(ptr) + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[IDX_W-1:0]]) begin
                    r.valid = 1'b1;
                    r.idx   = idx[IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cnt_sched_core.sv
// cnt_core: shared up-counter driven by the scheduler.
// Ports: clk, rst (async high), clr (sync clear), en (increment), count.
module cnt_core #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (clr)
            r_count <= '0;
        else if (en)
            r_count <= r_count + 1'b1;
    end

    assign count = r_count;

endmodule

// File: rtl/cnt_sched.sv
// cnt_sched: round-robin owner of one shared interval counter.
// Ports: clk, rst (async high), req/len in, gnt/done/busy/count out,
// abort in only when CNT_SCHED_ABORT_EN is defined.
module cnt_sched
    import cnt_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] len,
`ifdef CNT_SCHED_ABORT_EN
    input  logic [N_REQ-1:0]       abort,
`endif
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [CNT_W-1:0]       count
);

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_len_q;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_done;
    logic               r_busy;

    logic [MAX_REQ-1:0] w_req_pad;
    rr_pick_t           w_pick;
    logic [N_REQ-1:0]   w_win_oh;
    logic [CNT_W-1:0]   w_len_win;
    logic [CNT_W-1:0]   w_count;
    logic               w_at_end;
    logic               w_abort_hit;
    logic               w_clr;
    logic               w_en;

    always_comb begin
        w_req_pad             = '0;
        w_req_pad[N_REQ-1:0]  = req;
    end

    assign w_pick = rr_next(w_req_pad, r_ptr, N_REQ);

    always_comb begin
        w_win_oh  = '0;
        w_len_win = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick.idx == IDX_W'(i)) begin
                w_win_oh[i] = 1'b1;
                w_len_win   = len[i*CNT_W +: CNT_W];
            end
        end
    end

    assign w_at_end = (w_count == r_len_q);

    // r_gnt is nonzero only in RUN, so masking with it limits
    // abort to the current winner while running.
`ifdef CNT_SCHED_ABORT_EN
    assign w_abort_hit = |(abort & r_gnt);
`else
    assign w_abort_hit = 1'b0;
`endif

    // Counter is held cleared outside RUN and frozen at the end value
    // for the edge that moves to DONE.
    always_comb begin
        w_clr = 1'b1;
        w_en  = 1'b0;
        if (r_state == RUN && !w_abort_hit) begin
            w_clr = 1'b0;
            w_en  = !w_at_end;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= IDX_W'(N_REQ - 1);
            r_len_q <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_pick.valid) begin
                        r_state <= RUN;
                        r_ptr   <= w_pick.idx;
                        r_len_q <= w_len_win;
                        r_gnt   <= w_win_oh;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_abort_hit) begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (w_at_end) begin
                        r_state <= DONE;
                        r_gnt   <= '0;
                        r_done  <= r_gnt;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    cnt_core #(
        .W(CNT_W)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .en   (w_en),
        .count(w_count)
    );

    assign gnt   = r_gnt;
    assign done  = r_done;
    assign busy  = r_busy;
    assign count = w_count;

endmodule
